// File: rtl/an_code_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : an_code_pkg                                            |
// | Description : Constants, FSM state type and index-width helper       |
// |               shared by the AN-code encoder and decoder.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package an_code_pkg;

  // Default code configuration: A=13 protects an 8-bit N in 12 bits.
  localparam int c_def_a      = 13;
  localparam int c_def_data_w = 8;
  localparam int c_def_cw_w   = 12;

  // Decoder sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESID  = 3'd1,
    ST_SEARCH = 3'd2,
    ST_DIV    = 3'd3,
    ST_DONE   = 3'd4
  } an_state_t;

  // Bits needed to hold values 0..n-1 (never less than one bit).
  function automatic int idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/an_mod_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : an_mod_step                                            |
// | Description : One step of (2x + b) mod A with a single conditional  |
// |               subtract; x must already be below A. wrap reports that |
// |               the subtract happened (a quotient bit when dividing).  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module an_mod_step
  import an_code_pkg::*;
#(
  parameter int A  = c_def_a,
  parameter int RW = idx_w(c_def_a)
) (
  input  logic [RW-1:0] x,
  input  logic          b,
  output logic [RW-1:0] y,
  output logic          wrap
);

  localparam logic [RW:0]   c_a_ext = (RW+1)'(A);
  localparam logic [RW-1:0] c_a     = RW'(A);

  logic [RW:0] w_t;

  // Shift in the new bit, then fold back once; 2x+b < 2A so one subtract suffices.
  always_comb begin
    w_t  = {x, b};
    wrap = (w_t >= c_a_ext);
    y    = wrap ? (w_t[RW-1:0] - c_a) : w_t[RW-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/an_decoder_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : an_decoder_seq                                         |
// | Description : Bit-serial AN-code decoder. Computes CW mod A, finds   |
// |               and repairs a single flipped bit, divides by A.        |
// |               Fixed latency of 3*CW_W+1 cycles from accept.          |
// |               Optional AN_ERR_STATS_EN adds saturating counters of   |
// |               corrected / uncorrectable words.                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module an_decoder_seq
  import an_code_pkg::*;
#(
  parameter int A      = c_def_a,
  parameter int DATA_W = c_def_data_w,
  parameter int CW_W   = c_def_cw_w
`ifdef AN_ERR_STATS_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CW_W-1:0]          in_cw,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_corr,
  output logic                     out_uncorr,
  output logic [idx_w(CW_W)-1:0]   out_errbit
`ifdef AN_ERR_STATS_EN
  ,
  output logic [CNT_W-1:0]         stat_corr,
  output logic [CNT_W-1:0]         stat_uncorr
`endif
);

  localparam int              IW        = idx_w(CW_W);
  localparam int              RW        = idx_w(A);
  localparam logic [IW-1:0]   c_last    = IW'(CW_W - 1);
  localparam logic [IW-1:0]   c_cnt_one = IW'(1);
  localparam logic [RW-1:0]   c_a       = RW'(A);
  localparam logic [RW-1:0]   c_one     = RW'(1);

  an_state_t         r_state, w_next;
  logic [CW_W-1:0]   r_cw;        // codeword as received
  logic [CW_W-1:0]   r_corrcw;    // codeword after (optional) repair
  logic [RW-1:0]     r_r;         // residue CW mod A
  logic [RW-1:0]     r_p;         // 2^i mod A for the current search bit
  logic [RW-1:0]     r_rem;       // division remainder
  logic [DATA_W-1:0] r_q;         // quotient, keeps only the low DATA_W bits
  logic [IW-1:0]     r_cnt;
  logic [IW-1:0]     r_errbit;
  logic              r_found;
  logic              r_uncorr;

  logic              w_last;
  logic [IW-1:0]     w_idx;
  logic [RW-1:0]     w_sx, w_sy;
  logic              w_sb, w_wrap;
  logic [CW_W-1:0]   w_pow;
  logic [CW_W:0]     w_sum;
  logic              w_bit_i, w_match;

  // Single shared modulo step; the three phases never need it at once.
  an_mod_step #(.A(A), .RW(RW)) u_step (
    .x    (w_sx),
    .b    (w_sb),
    .y    (w_sy),
    .wrap (w_wrap)
  );

  // Route residue, power-of-two or remainder through the modulo step.
  always_comb begin
    w_last = (r_cnt == c_last);
    w_idx  = c_last - r_cnt;
    w_sx   = '0;
    w_sb   = 1'b0;
    case (r_state)
      ST_RESID:  begin w_sx = r_r;   w_sb = r_cw[w_idx];     end
      ST_SEARCH: begin w_sx = r_p;   w_sb = 1'b0;            end
      ST_DIV:    begin w_sx = r_rem; w_sb = r_corrcw[w_idx]; end
      default:   begin w_sx = '0;    w_sb = 1'b0;            end
    endcase
  end

  // Bit i explains the residue if removing a set bit or adding a clear bit zeroes it.
  always_comb begin
    w_pow   = {{(CW_W-1){1'b0}}, 1'b1} << r_cnt;
    w_sum   = {1'b0, r_cw} + {1'b0, w_pow};
    w_bit_i = r_cw[r_cnt];
    w_match = (r_r != '0) &&
              (( w_bit_i && (r_r == r_p)) ||
               (!w_bit_i && (r_r == (c_a - r_p)) && !w_sum[CW_W]));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: each working phase lasts exactly CW_W cycles.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (in_valid)  w_next = ST_RESID;
      ST_RESID:  if (w_last)    w_next = ST_SEARCH;
      ST_SEARCH: if (w_last)    w_next = ST_DIV;
      ST_DIV:    if (w_last)    w_next = ST_DONE;
      ST_DONE:   if (out_ready) w_next = ST_IDLE;
      default:                  w_next = ST_IDLE;
    endcase
  end

  // Outputs: handshake from the state, result straight from the datapath registers.
  always_comb begin
    in_ready   = (r_state == ST_IDLE);
    out_valid  = (r_state == ST_DONE);
    out_data   = r_q;
    out_corr   = r_found;
    out_uncorr = r_uncorr;
    out_errbit = r_errbit;
  end

  // Datapath: residue, correction search and restoring division.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cw     <= '0;
      r_corrcw <= '0;
      r_r      <= '0;
      r_p      <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_errbit <= '0;
      r_found  <= 1'b0;
      r_uncorr <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_cw     <= in_cw;
          r_corrcw <= in_cw;
          r_r      <= '0;
          r_p      <= c_one;
          r_rem    <= '0;
          r_q      <= '0;
          r_cnt    <= '0;
          r_errbit <= '0;
          r_found  <= 1'b0;
          r_uncorr <= 1'b0;
        end
        ST_RESID: begin
          r_r   <= w_sy;
          r_cnt <= w_last ? '0 : r_cnt + c_cnt_one;
        end
        ST_SEARCH: begin
          r_p   <= w_sy;
          r_cnt <= w_last ? '0 : r_cnt + c_cnt_one;
          // Lowest matching bit wins; later matches are ignored.
          if (w_match && !r_found) begin
            r_found  <= 1'b1;
            r_errbit <= r_cnt;
            r_corrcw <= w_bit_i ? (r_cw - w_pow) : w_sum[CW_W-1:0];
          end
          if (w_last) r_uncorr <= (r_r != '0) && !r_found && !w_match;
        end
        ST_DIV: begin
          r_rem <= w_sy;
          r_q   <= (r_q << 1) | DATA_W'(w_wrap);
          r_cnt <= w_last ? '0 : r_cnt + c_cnt_one;
        end
        default: ;
      endcase
    end
  end

`ifdef AN_ERR_STATS_EN
  localparam logic [CNT_W-1:0] c_stat_one = CNT_W'(1);
  logic [CNT_W-1:0] r_stat_corr, r_stat_uncorr;

  // Count delivered words by outcome, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_corr   <= '0;
      r_stat_uncorr <= '0;
    end else if ((r_state == ST_DONE) && out_ready) begin
      if (r_found  && (r_stat_corr   != '1)) r_stat_corr   <= r_stat_corr   + c_stat_one;
      if (r_uncorr && (r_stat_uncorr != '1)) r_stat_uncorr <= r_stat_uncorr + c_stat_one;
    end
  end

  assign stat_corr   = r_stat_corr;
  assign stat_uncorr = r_stat_uncorr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_an_decoder_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_an_decoder_seq                                      |
// | Description : Scoreboard bench for an_decoder_seq (A=13, 8/12 bits). |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_an_decoder_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_cw = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_corr;
  logic        out_uncorr;
  logic [3:0]  out_errbit;
`ifdef AN_ERR_STATS_EN
  logic [1:0]  stat_corr;
  logic [1:0]  stat_uncorr;
`endif

  an_decoder_seq #(
    .A(13), .DATA_W(8), .CW_W(12)
`ifdef AN_ERR_STATS_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cw      (in_cw),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_corr   (out_corr),
    .out_uncorr (out_uncorr),
    .out_errbit (out_errbit)
`ifdef AN_ERR_STATS_EN
    ,
    .stat_corr  (stat_corr),
    .stat_uncorr(stat_uncorr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int corr;
    int uncorr;
    int errbit;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   xfers = 0;
  int   t_acc = 0;
  int   t_val = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Independent reference: flip each bit in turn, take the first that yields a multiple of 13.
  task automatic model(input int cw, output int d, output int c, output int u, output int eb);
    int f;
    f = cw; c = 0; u = 0; eb = 0;
    if (cw % 13 != 0) begin
      for (int i = 0; i < 12; i++) begin
        if (c == 0 && ((cw ^ (1 << i)) % 13) == 0) begin
          c = 1; eb = i; f = cw ^ (1 << i);
        end
      end
      if (c == 0) u = 1;
    end
    d = (f / 13) % 256;
  endtask

  // Monitor: timestamps accept and first valid, pops the scoreboard on each transfer.
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (in_valid && in_ready) t_acc = cyc;
      if (out_valid && !prev_v) t_val = cyc;
      prev_v = out_valid;
      if (out_valid && out_ready) begin
        xfers++;
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got data %0d, required no output", out_data);
        end else begin
          e = sb.pop_front();
          check("out_data",   int'(out_data),   e.data);
          check("out_corr",   int'(out_corr),   e.corr);
          check("out_uncorr", int'(out_uncorr), e.uncorr);
          check("out_errbit", int'(out_errbit), e.errbit);
          check("latency",    t_val - t_acc,    37);
        end
      end
    end
  end

  // Offer one codeword; returns one cycle after it was accepted.
  task automatic send(input int cw, input bit push, input int d, input int c, input int u, input int eb);
    int k;
    if (push) sb.push_back('{d, c, u, eb});
    in_cw    = 12'(cw);
    in_valid = 1'b1;
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      if (in_ready) break;
      k++;
    end
    if (k >= 100) timeout("accept");
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run(input int cw, input int d, input int c, input int u, input int eb);
    int x0, k;
    x0 = xfers;
    send(cw, 1'b1, d, c, u, eb);
    k = 0;
    while (xfers == x0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (xfers == x0) timeout("result");
    @(posedge clk);
    #1;
  endtask

  // Directed vectors: codeword, N, corr, uncorr, errbit.
  int vec [12][5] = '{
    '{3276, 252, 0, 0, 0},
    '{3277, 252, 1, 0, 0},
    '{3278, 252, 1, 0, 1},
    '{3292, 252, 1, 0, 4},
    '{3308, 252, 1, 0, 5},
    '{3532, 252, 1, 0, 8},
    '{3788, 252, 1, 0, 9},
    '{3272, 252, 1, 0, 2},
    '{66,   5,   0, 1, 0},
    '{0,    0,   0, 0, 0},
    '{4095, 59,  0, 0, 0},
    '{3319, 255, 1, 0, 2}
  };

  initial begin
    int d, c, u, eb, found, cw, k, seen, x0;

    // Reset values.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",   int'(in_ready),   1);
    check("rst_out_valid",  int'(out_valid),  0);
    check("rst_out_corr",   int'(out_corr),   0);
    check("rst_out_uncorr", int'(out_uncorr), 0);
    check("rst_out_data",   int'(out_data),   0);
    check("rst_out_errbit", int'(out_errbit), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vec[i]) run(vec[i][0], vec[i][1], vec[i][2], vec[i][3], vec[i][4]);

    // A few uncorrectable words picked from a stride scan by the reference model.
    found = 0;
    cw    = 101;
    for (int i = 0; i < 400 && found < 5; i++) begin
      model(cw, d, c, u, eb);
      if (u == 1) begin
        run(cw, d, c, u, eb);
        found++;
      end
      cw = (cw + 389) % 4096;
    end
    check("uncorr_vectors_found", found, 5);

    // Back-pressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    send(3277, 1'b1, 252, 1, 0, 0);
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) timeout("bp_valid");
    repeat (10) begin
      @(negedge clk);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_in_ready",  int'(in_ready),  0);
      check("bp_out_data",  int'(out_data),  252);
      check("bp_out_corr",  int'(out_corr),  1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    x0 = xfers;
    @(posedge clk);
    #1;
    check("bp_one_transfer", xfers - x0,       1);
    check("bp_in_ready_after", int'(in_ready), 1);
    check("bp_valid_dropped",  int'(out_valid), 0);

    // Reset while dividing: that word must never appear.
    send(3278, 1'b0, 0, 0, 0, 0);
    repeat (27) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_in_ready",  int'(in_ready),  1);
    check("abort_out_corr",  int'(out_corr),  0);
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("abort_no_output", seen, 0);
    @(posedge clk);
    #1;
    run(3277, 252, 1, 0, 0);

`ifdef AN_ERR_STATS_EN
    // Two-bit counters saturate at 3 after five corrected words.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("stat_corr_reset", int'(stat_corr), 0);
    @(posedge clk);
    #1;
    run(3277, 252, 1, 0, 0);
    run(3278, 252, 1, 0, 1);
    run(3292, 252, 1, 0, 4);
    run(3308, 252, 1, 0, 5);
    run(3532, 252, 1, 0, 8);
    @(negedge clk);
    check("stat_corr_sat",  int'(stat_corr),   3);
    check("stat_uncorr",    int'(stat_uncorr), 0);
`endif

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global bound so a stuck DUT cannot hang the run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no completion, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
